// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB-lite arbiter that lets up to four masters share
// the single AHB slave port of the AHB-to-APB bridge.
//
// It tracks three kinds of owner: the grant owner (hgrant), the address-phase
// owner (hmaster) and the data-phase owner. It muxes the address-phase owner's
// address and control, and the data-phase owner's write data, onto the bridge
// input. Bus locking and a tenure limit give lock support and fairness.
//
// Ports:
//   hclk       in   clock; all state changes on its rising edge
//   hresetn    in   asynchronous active-low reset
//   hbusreq    in   [N]     per-master bus request
//   hlock      in   [N]     per-master lock request
//   htrans_m   in   [2N]    per-master HTRANS, master i at [2i+1:2i]
//   haddr_m    in   [32N]   per-master address, master i at [32i+31:32i]
//   hwrite_m   in   [N]     per-master write flag
//   hwdata_m   in   [32N]   per-master write data, sliced like haddr_m
//   hready     in   bridge ready; enables every register
//   hgrant     out  [N]     one-hot grant
//   hmaster    out  [2]     address-phase owner index
//   hmastlock  out  current transfer is locked
//   htrans     out  [2]     HTRANS of the address-phase owner
//   haddr      out  [32]    address of the address-phase owner
//   hwrite     out  write flag of the address-phase owner
//   hwdata     out  [32]    write data of the data-phase owner
module ahb_arbiter #(
    parameter int unsigned N         = 3,
    parameter int unsigned DEFAULT_M = 0,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic [N-1:0]    hbusreq,
    input  logic [N-1:0]    hlock,
    input  logic [2*N-1:0]  htrans_m,
    input  logic [32*N-1:0] haddr_m,
    input  logic [N-1:0]    hwrite_m,
    input  logic [32*N-1:0] hwdata_m,
    input  logic            hready,
    output logic [N-1:0]    hgrant,
    output logic [1:0]      hmaster,
    output logic            hmastlock,
    output logic [1:0]      htrans,
    output logic [31:0]     haddr,
    output logic            hwrite,
    output logic [31:0]     hwdata
);

    localparam logic [1:0]   TransBusy = 2'b01;
    localparam logic [1:0]   TransSeq  = 2'b11;
    localparam logic [1:0]   DefIdx    = 2'(DEFAULT_M);
    localparam logic [N-1:0] DefGrant  = N'(1) << DEFAULT_M;
    localparam logic [7:0]   MaxBeats  = 8'(MAX_BEATS);

    logic [N-1:0] grant_q, grant_d;
    logic [1:0]   master_q;
    logic [1:0]   data_master_q;
    logic         mastlock_q;
    logic [7:0]   tenure_q, tenure_d;

    logic [1:0]   g_idx;
    logic [1:0]   next_idx;
    logic         lock_g;
    logic         hold;
    int unsigned  best_dist;

    // Round-robin distance of master i from the current owner g. The owner itself
    // gets the largest distance so it is considered last.
    function automatic int unsigned rr_dist(int unsigned i, int unsigned g);
        int unsigned d;
        d = (i + N - g) % N;
        return (d == 0) ? N : d;
    endfunction

    // Decode the one-hot grant into an index and pick up the owner's lock request.
    always_comb begin
        g_idx  = DefIdx;
        lock_g = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                g_idx = 2'(i);
            end
            lock_g = lock_g | (grant_q[i] & hlock[i]);
        end
    end

    // Address/control follow the address-phase owner, write data the data-phase owner.
    always_comb begin
        htrans = '0;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (master_q == 2'(i)) begin
                htrans = htrans_m[2*i +: 2];
                haddr  = haddr_m[32*i +: 32];
                hwrite = hwrite_m[i];
            end
            if (data_master_q == 2'(i)) begin
                hwdata = hwdata_m[32*i +: 32];
            end
        end
    end

    // Arbitration. A burst in progress holds the grant until the tenure limit;
    // a lock holds it regardless of tenure.
    always_comb begin
        hold      = lock_g |
                    (((htrans == TransSeq) || (htrans == TransBusy)) && (tenure_q < MaxBeats));
        next_idx  = g_idx;
        best_dist = N + 1;
        if (!hold) begin
            if (|hbusreq) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (hbusreq[i] && (rr_dist(i, {30'd0, g_idx}) < best_dist)) begin
                        best_dist = rr_dist(i, {30'd0, g_idx});
                        next_idx  = 2'(i);
                    end
                end
            end else begin
                next_idx = DefIdx;
            end
        end

        grant_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant_d[i] = (next_idx == 2'(i));
        end

        // NONSEQ and SEQ both have htrans[1] set.
        if (next_idx != g_idx) begin
            tenure_d = '0;
        end else if (htrans[1] && (tenure_q < MaxBeats)) begin
            tenure_d = tenure_q + 8'd1;
        end else begin
            tenure_d = tenure_q;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q       <= DefGrant;
            master_q      <= DefIdx;
            data_master_q <= DefIdx;
            mastlock_q    <= 1'b0;
            tenure_q      <= '0;
        end else if (hready) begin
            grant_q       <= grant_d;
            master_q      <= g_idx;
            data_master_q <= master_q;
            mastlock_q    <= lock_g;
            tenure_q      <= tenure_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = master_q;
    assign hmastlock = mastlock_q;

endmodule
